// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Brief    : Serial line input and received-byte outputs of the UART receiver.
// Revision : 1.0
// ============================================================================
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    // master: the receiver itself; slave: the byte consumer
    modport master (
        input  rx,
        output data, valid, parity_err, frame_err, busy
    );
    modport slave (
        input  rx, data, valid, parity_err, frame_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8O1 UART receiver, mid-bit sampling, byte strobe with error flags.
// Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 50000
) (
    input  wire         CLOCK_50,
    input  wire         RESET_N,
    uart_rx_if.master   bus
);
    localparam int c_CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CW-1:0] c_LAST    = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_HALF_M1 = c_CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_sync;
    logic [c_CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]      r_idx, w_idx_nxt;
    logic [7:0]      r_shift;
    logic            r_par;
    logic [7:0]      r_data;
    logic            r_valid, r_perr, r_ferr;
    logic            w_rx_s, w_shift_en, w_par_en, w_load;

    assign w_rx_s = r_sync[1];

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync  <= 2'b11;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_sync  <= {r_sync[0], bus.rx};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_en  = 1'b0;
        w_par_en    = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rx_s) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_cnt == c_HALF_M1) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    // a line already back high at mid-start was only a glitch
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == c_LAST) begin
                    w_cnt_nxt  = '0;
                    w_shift_en = 1'b1;
                    w_idx_nxt  = r_idx + 3'd1;
                    if (r_idx == 3'd7) w_state_nxt = S_PARITY;
                end
            end
            S_PARITY: begin
                if (r_cnt == c_LAST) begin
                    w_cnt_nxt   = '0;
                    w_par_en    = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == c_LAST) begin
                    w_cnt_nxt   = '0;
                    w_load      = 1'b1;
                    w_state_nxt = w_rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                w_cnt_nxt = '0;
                if (w_rx_s) w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_shift <= '0;
            r_par   <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= w_load;
            if (w_shift_en) r_shift[r_idx] <= w_rx_s;
            if (w_par_en)   r_par <= w_rx_s;
            if (w_load) begin
                r_data <= r_shift;
                // odd parity: an even total of ones across data+parity is an error
                r_perr <= ~(^{r_shift, r_par});
                r_ferr <= ~w_rx_s;
            end
        end
    end

    assign bus.data       = r_data;
    assign bus.valid      = r_valid;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
    assign bus.busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Scoreboard bench for uart_rx with 16 clocks per bit.
// Revision : 1.0
// ============================================================================
module tb_uart_rx;
    localparam int c_CPB = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic CLOCK_50;
    logic RESET_N;
    int   n_tests;
    int   n_fail;
    exp_t q[$];
    exp_t last_exp;
    logic prev_valid;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(c_CPB)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .bus      (bus.master)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, required 0x%02h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every valid strobe must match the oldest expected frame
    initial begin
        prev_valid = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            if (prev_valid) chk("valid_width", {7'd0, bus.valid}, 8'h00);
            if (bus.valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got valid with data=0x%02h, required no valid at %0t",
                             bus.data, $time);
                end else begin
                    last_exp = q.pop_front();
                    chk("data", bus.data, last_exp.d);
                    chk("parity_err", {7'd0, bus.parity_err}, {7'd0, last_exp.pe});
                    chk("frame_err", {7'd0, bus.frame_err}, {7'd0, last_exp.fe});
                end
            end
            prev_valid = (bus.valid === 1'b1);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // rst_bit >= 0 aborts the frame with a reset in the middle of that data bit
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int rst_bit, input int hold_low);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            bus.rx = bits[i];
            if (rst_bit >= 0 && i == rst_bit + 1) begin
                idle(c_CPB / 2);
                RESET_N = 1'b0;
                idle(1);
                chk("rst_data", bus.data, 8'h00);
                chk("rst_valid", {7'd0, bus.valid}, 8'h00);
                chk("rst_perr", {7'd0, bus.parity_err}, 8'h00);
                chk("rst_ferr", {7'd0, bus.frame_err}, 8'h00);
                chk("rst_busy", {7'd0, bus.busy}, 8'h00);
                last_exp = '0;
                bus.rx = 1'b1;
                idle(2);
                RESET_N = 1'b1;
                return;
            end
            idle(c_CPB);
        end
        if (!s) idle(hold_low);
        bus.rx = 1'b1;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (q.size() != 0 && t < 400) begin
            idle(1);
            t++;
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d frames still undelivered, required 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        last_exp = '0;
        RESET_N  = 1'b0;
        bus.rx   = 1'b1;
        idle(3);
        chk("reset_data", bus.data, 8'h00);
        chk("reset_valid", {7'd0, bus.valid}, 8'h00);
        chk("reset_busy", {7'd0, bus.busy}, 8'h00);
        chk("reset_flags", {6'd0, bus.parity_err, bus.frame_err}, 8'h00);
        RESET_N = 1'b1;
        idle(5);

        // 0xA5: four ones + parity 1 -> odd, no errors
        q.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
        send_frame(8'hA5, 1'b1, 1'b1, -1, 0);
        drain("frame_a5");
        idle(4);
        chk("busy_after_a5", {7'd0, bus.busy}, 8'h00);

        // Back-to-back with no idle gap
        q.push_back('{d: 8'h07, pe: 1'b0, fe: 1'b0});
        q.push_back('{d: 8'hFF, pe: 1'b0, fe: 1'b0});
        send_frame(8'h07, 1'b0, 1'b1, -1, 0);
        send_frame(8'hFF, 1'b1, 1'b1, -1, 0);
        drain("back_to_back");
        idle(10);

        // 0x3C has four ones; parity 0 leaves an even total
        q.push_back('{d: 8'h3C, pe: 1'b1, fe: 1'b0});
        send_frame(8'h3C, 1'b0, 1'b1, -1, 0);
        drain("parity_bad");
        idle(10);
        chk("perr_held", {7'd0, bus.parity_err}, 8'h01);
        q.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0});
        send_frame(8'h3C, 1'b1, 1'b1, -1, 0);
        drain("parity_good");
        idle(10);

        // Stop bit 0 then line held low: one strobe, busy until line recovers
        q.push_back('{d: 8'h55, pe: 1'b0, fe: 1'b1});
        send_frame(8'h55, 1'b1, 1'b0, -1, 40);
        chk("busy_in_break", {7'd0, bus.busy}, 8'h01);
        drain("break_frame");
        idle(6);
        chk("busy_after_break", {7'd0, bus.busy}, 8'h00);
        idle(10);

        // Start glitch of 5 cycles, shorter than half a bit
        bus.rx = 1'b0;
        idle(4);
        chk("glitch_busy_hi", {7'd0, bus.busy}, 8'h01);
        idle(1);
        bus.rx = 1'b1;
        idle(30);
        chk("glitch_busy_lo", {7'd0, bus.busy}, 8'h00);
        chk("glitch_data", bus.data, last_exp.d);
        chk("glitch_flags", {6'd0, bus.parity_err, bus.frame_err}, {6'd0, last_exp.pe, last_exp.fe});

        // Reset during data bit 4, then a clean frame
        send_frame(8'h81, 1'b1, 1'b1, 4, 0);
        idle(30);
        chk("post_rst_data", bus.data, 8'h00);
        q.push_back('{d: 8'h81, pe: 1'b0, fe: 1'b0});
        send_frame(8'h81, 1'b1, 1'b1, -1, 0);
        drain("frame_81");
        idle(20);
        chk("final_busy", {7'd0, bus.busy}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Receiver end of the board's 11-bit UART link: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1, at 1000 baud from the 50 MHz clock. The block synchronizes the serial line, finds each frame by its start edge and samples every bit at mid-bit. It then presents the received byte with a one-cycle strobe plus parity and framing error flags. It sits between the board's serial input pin and the display/LED logic that consumes received bytes.

## Interface
- CLKS_PER_BIT, 50000, system clocks per bit (50 MHz / 1000 baud); must be ≥ 4
- CLOCK_50  input  1  system clock; all logic on its rising edge
- RESET_N  input  1  asynchronous, active-low reset
- rx  input  1  serial line, idle high, asynchronous to CLOCK_50
- data  output  8  last received byte; updated only at frame completion
- valid  output  1  one-cycle strobe: data and error flags are new
- parity_err  output  1  parity check result of the last frame; 1 = parity not odd
- frame_err  output  1  stop-bit check result of the last frame; 1 = stop sampled 0
- busy  output  1  high while a frame is being received (any state except IDLE)

## Operation
- rx passes through a 2-flop synchronizer (reset value 1). Only the synchronized rx_s is used.
- Bit counter `cnt` (width clog2(CLKS_PER_BIT)) and bit index `idx` (3 bits).
- HALF = CLKS_PER_BIT/2 (floor).
- IDLE: cnt=0. On rx_s==0, go to START.
- START: count to HALF-1.
  - If rx_s==1 at that sample, it is a glitch. Return to IDLE with no valid and no flag change.
  - Otherwise clear cnt and idx, then go to DATA.
- DATA: at cnt==CLKS_PER_BIT-1, sample rx_s into shift[idx] (LSB first) and reset cnt. After idx==7, go to PARITY.
- PARITY: at the full bit period, sample p. Compute perr = ~(^{shift,p}), so an odd total count of ones is correct.
- STOP: at the full bit period, sample the stop bit.
  - Load data<=shift, parity_err<=perr, frame_err<=~rx_s, and pulse valid.
  - If the stop bit was 1, go to IDLE. If it was 0, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A line held low never re-triggers START.
- A byte with an error is still delivered: data is loaded and valid pulses. The consumer decides what to do with it.
- Flags hold their value until the next frame completes.
- Reset mid-frame: everything returns to reset values at once. The partial frame is discarded and no valid is produced.

## Timing
- Reset values: data=0x00, valid=0, parity_err=0, frame_err=0, busy=0, synchronizer=1, state=IDLE.
- Synchronizer latency is 2 cycles from an rx change to rx_s.
- The start sample occurs HALF cycles after the first IDLE cycle that sees rx_s==0. Every following sample is exactly CLKS_PER_BIT cycles after the previous one.
- valid is asserted in the cycle after the stop sample. This is 2 + HALF + 10·CLKS_PER_BIT (±1) cycles after the rx falling edge, which is 525002 cycles at default.
- valid is high for exactly 1 cycle. data and flags change only in that same cycle.
- busy rises the cycle after rx_s falls. It falls when the state returns to IDLE: after the stop sample, or after the line recovers in BREAK.
- Back-to-back frames: a new start edge seen in the cycle after returning to IDLE is accepted. There is no minimum idle gap beyond the stop bit.
- A start glitch shorter than HALF cycles produces no output.

## Test plan
Run with CLKS_PER_BIT=16; the driver sends bits 16 cycles wide.
- Send 0xA5 with parity=1 and stop=1 → one valid pulse, data=0xA5, parity_err=0, frame_err=0, busy low afterwards.
- Send 0x07 with parity=0 immediately followed by 0xFF with parity=1 → two valid pulses, data=0x07 then 0xFF, no errors, no byte lost.
- Send 0x3C with parity=0 (wrong; correct is 1) → valid, data=0x3C, parity_err=1. Then a correct frame clears it to 0.
- Send 0x55 with stop=0 and hold rx low for 40 cycles → valid once, frame_err=1, no second valid while the line is low, busy falls only after rx returns high.
- Pull rx low for 5 cycles then release (< HALF=8) → no valid, busy pulses then returns 0, outputs unchanged.
- Assert RESET_N=0 during data bit 4 of a frame → all outputs at reset values, no valid. Then a full 0x81 frame with parity=1 → data=0x81, no errors.
